// File: rtl/ahb_sram_responder_if.sv
// AHB-Lite bus bundle between the interconnect (master side) and the SRAM responder (slave side).
interface ahb_sram_responder_if;
  logic        hsel;
  logic        hready_in;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic        is_signed;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport master (
    output hsel, hready_in, haddr, htrans, hwrite, hsize, hprot, is_signed, hwdata,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, hready_in, haddr, htrans, hwrite, hsize, hprot, is_signed, hwdata,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_sram_responder.sv
// AHB-Lite SRAM responder: programmable wait states, byte/half/word access, extended loads, two-cycle ERROR.
// Defining AHB_SRAM_WRITE_PROTECT_EN refuses writes to byte offsets below RO_LIMIT.
//
// state | meaning
// IDLE  | no data phase stretched; final data cycle of a transfer when pend_q is set
// WAIT  | data phase stretched, wait counter running down
// ERR1  | first ERROR cycle, hreadyout low
// ERR2  | second ERROR cycle, hreadyout high, new address phase may be sampled
module ahb_sram_responder #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] RO_LIMIT    = 32'h100
) (
  input logic                 clk,
  input logic                 reset,
  ahb_sram_responder_if.slave bus
);
  localparam int         OFF_W   = ADDR_W + 2;
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               latch;
  logic [OFF_W-1:0]   addr_q;
  logic [1:0]         size_q;
  logic               write_q;
  logic               signed_q;
  logic [31:0]        hrdata_q;
  logic [31:0]        mem [2**ADDR_W];

  logic               sample;
  logic               illegal;
  logic               wr_prot;
  logic [OFF_W-1:0]   offset;
  logic [ADDR_W-1:0]  widx;
  logic [3:0]         be;
  logic [31:0]        word;
  logic [31:0]        shifted;
  logic [31:0]        rd_ext;
  logic               unused_ok;

  assign offset    = bus.haddr[OFF_W-1:0];
  assign sample    = bus.hsel & bus.hready_in & bus.htrans[1];
  assign unused_ok = ^{bus.hprot, RO_LIMIT};

`ifdef AHB_SRAM_WRITE_PROTECT_EN
  assign wr_prot = bus.hwrite && (32'(offset) < RO_LIMIT);
`else
  assign wr_prot = 1'b0;
`endif

  always_comb begin
    illegal = 1'b0;
    if (bus.hsize > 3'd2) illegal = 1'b1;
    if (bus.hsize == 3'd1 && bus.haddr[0]) illegal = 1'b1;
    if (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00) illegal = 1'b1;
    if ((bus.haddr >> OFF_W) != 32'd0) illegal = 1'b1;
    if (wr_prot) illegal = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    latch   = 1'b0;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        if (sample) begin
          if (illegal) begin
            state_d = S_ERR1;
          end else begin
            latch = 1'b1;
            if (WAIT_STATES == 0) begin
              pend_d = 1'b1;
            end else begin
              state_d = S_WAIT;
              cnt_d   = WS_LOAD;
            end
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_IDLE;
          pend_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      pend_q   <= 1'b0;
      hrdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (pend_q && !write_q) hrdata_q <= rd_ext;
    end
  end

  // Address-phase capture; overwritten in the final data cycle when transfers are pipelined.
  always_ff @(posedge clk) begin
    if (latch) begin
      addr_q   <= offset;
      size_q   <= bus.hsize[1:0];
      write_q  <= bus.hwrite;
      signed_q <= bus.is_signed;
    end
  end

  assign widx = addr_q[OFF_W-1:2];

  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'd0:    be = 4'b0001 << addr_q[1:0];
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Write data arrives on address-aligned byte lanes.
  always_ff @(posedge clk) begin
    if (!reset && pend_q && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  assign word = mem[widx];

  // Half accesses are 2-aligned, so the byte shift also serves them.
  always_comb begin
    shifted = word >> {addr_q[1:0], 3'b000};
    rd_ext  = word;
    case (size_q)
      2'd0:    rd_ext = signed_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
      2'd1:    rd_ext = signed_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'd0, shifted[15:0]};
      default: rd_ext = word;
    endcase
  end

  assign bus.hrdata    = (pend_q && !write_q) ? rd_ext : hrdata_q;
  assign bus.hreadyout = !(state_q == S_WAIT || state_q == S_ERR1);
  assign bus.hresp     = (state_q == S_ERR1 || state_q == S_ERR2);
endmodule

// File: tb/tb_ahb_sram_responder.sv
// Directed self-checking bench for ahb_sram_responder (WAIT_STATES=1, ADDR_W=10).
`timescale 1ns/1ps
module tb_ahb_sram_responder;
  localparam int WS = 1;

  logic clk = 1'b0;
  logic reset;
  int   vec  = 0;
  int   errs = 0;

  ahb_sram_responder_if bus();

  ahb_sram_responder #(.ADDR_W(10), .WAIT_STATES(WS), .RO_LIMIT(32'h100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic bus_idle();
    bus.hsel = 1'b0; bus.hready_in = 1'b1; bus.haddr = 32'd0; bus.htrans = 2'b00;
    bus.hwrite = 1'b0; bus.hsize = 3'd0; bus.hprot = 4'h3; bus.is_signed = 1'b0; bus.hwdata = 32'd0;
  endtask

  // One non-pipelined transfer; control inputs are scrambled during the data phase so latching is exercised.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size, input logic sgn,
                      input logic [31:0] wdata, output logic [31:0] rdata, output int lows,
                      output logic resp_low, output logic resp_fin);
    bit done;
    done = 0;
    @(negedge clk);
    bus.hsel = 1'b1; bus.hready_in = 1'b1; bus.htrans = 2'b10; bus.haddr = addr;
    bus.hwrite = wr; bus.hsize = size; bus.is_signed = sgn;
    @(negedge clk);
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = wdata;
    bus.is_signed = ~sgn; bus.hwrite = ~wr; bus.hsize = 3'd0; bus.haddr = 32'h3FC;
    lows = 0; resp_low = 1'b0; resp_fin = 1'b0; rdata = 32'hxxxxxxxx;
    for (int i = 0; i < 16 && !done; i++) begin
      if (bus.hreadyout === 1'b1) begin
        done = 1; rdata = bus.hrdata; resp_fin = bus.hresp;
      end else begin
        lows++; resp_low |= bus.hresp;
        @(negedge clk);
      end
    end
    vec++;
    if (!done) begin
      errs++;
      $display("FAIL xfer_timeout addr=%h got no hreadyout within 16 cycles, want completion", addr);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vec++; if (bus.hreadyout !== 1'b1) begin errs++; $display("FAIL reset_hreadyout got=%b want=1", bus.hreadyout); end
    vec++; if (bus.hresp !== 1'b0) begin errs++; $display("FAIL reset_hresp got=%b want=0", bus.hresp); end
    vec++; if (bus.hrdata !== 32'd0) begin errs++; $display("FAIL reset_hrdata got=%h want=00000000", bus.hrdata); end
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; int lows; logic rl, rf;
    xfer(1'b1, 32'h200, 3'd2, 1'b0, 32'hDEADBEEF, rd, lows, rl, rf);
    vec++; if (lows !== WS || rl !== 1'b0 || rf !== 1'b0) begin
      errs++; $display("FAIL word_write_phase lows=%0d resp=%b%b want lows=%0d resp=00", lows, rl, rf, WS); end
    xfer(1'b0, 32'h200, 3'd2, 1'b0, 32'h0, rd, lows, rl, rf);
    vec++; if (lows !== WS || rl !== 1'b0 || rf !== 1'b0) begin
      errs++; $display("FAIL word_read_phase lows=%0d resp=%b%b want lows=%0d resp=00", lows, rl, rf, WS); end
    vec++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL word_read_data got=%h want=DEADBEEF", rd); end
  endtask

  task automatic test_subword_read();
    logic [31:0] addrs [6] = '{32'h203, 32'h203, 32'h200, 32'h202, 32'h202, 32'h200};
    logic [2:0]  sizes [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
    logic        sgns  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] exps  [6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFFFEF, 32'h000000AD, 32'h0000DEAD, 32'hFFFFBEEF};
    logic [31:0] rd; int lows; logic rl, rf;
    for (int i = 0; i < 6; i++) begin
      xfer(1'b0, addrs[i], sizes[i], sgns[i], 32'h0, rd, lows, rl, rf);
      vec++; if (rd !== exps[i] || rf !== 1'b0) begin
        errs++; $display("FAIL subword_read[%0d] addr=%h got=%h resp=%b want=%h resp=0", i, addrs[i], rd, rf, exps[i]); end
    end
  endtask

  task automatic test_partial_write();
    logic [31:0] rd; int lows; logic rl, rf;
    xfer(1'b1, 32'h202, 3'd1, 1'b0, 32'h12341234, rd, lows, rl, rf);
    xfer(1'b0, 32'h200, 3'd2, 1'b0, 32'h0, rd, lows, rl, rf);
    vec++; if (rd !== 32'h1234BEEF) begin errs++; $display("FAIL half_write got=%h want=1234BEEF", rd); end
    xfer(1'b1, 32'h201, 3'd0, 1'b0, 32'hA5A5A5A5, rd, lows, rl, rf);
    xfer(1'b0, 32'h200, 3'd2, 1'b0, 32'h0, rd, lows, rl, rf);
    vec++; if (rd !== 32'h1234A5EF) begin errs++; $display("FAIL byte_write got=%h want=1234A5EF", rd); end
    xfer(1'b0, 32'h201, 3'd0, 1'b1, 32'h0, rd, lows, rl, rf);
    vec++; if (rd !== 32'hFFFFFFA5) begin errs++; $display("FAIL byte_read_signed got=%h want=FFFFFFA5", rd); end
  endtask

  task automatic test_error();
    logic        wrs   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] addrs [4] = '{32'h201, 32'h200, 32'h203, 32'h1200};
    logic [2:0]  sizes [4] = '{3'd2, 3'd3, 3'd1, 3'd2};
    logic [31:0] rd; int lows; logic rl, rf;
    for (int i = 0; i < 4; i++) begin
      xfer(wrs[i], addrs[i], sizes[i], 1'b0, 32'hFFFFFFFF, rd, lows, rl, rf);
      vec++; if (lows !== 1 || rl !== 1'b1 || rf !== 1'b1) begin
        errs++; $display("FAIL error_pair[%0d] lows=%0d resp=%b%b want lows=1 resp=11", i, lows, rl, rf); end
    end
    xfer(1'b0, 32'h200, 3'd2, 1'b0, 32'h0, rd, lows, rl, rf);
    vec++; if (rd !== 32'h1234A5EF || rf !== 1'b0) begin
      errs++; $display("FAIL error_no_commit got=%h resp=%b want=1234A5EF resp=0", rd, rf); end
  endtask

  // Write data phase overlaps the read address phase.
  task automatic test_back_to_back();
    @(negedge clk);
    bus.hsel = 1'b1; bus.hready_in = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h208;
    bus.hwrite = 1'b1; bus.hsize = 3'd2; bus.is_signed = 1'b0;
    @(negedge clk);
    vec++; if (bus.hreadyout !== 1'b0) begin errs++; $display("FAIL b2b_write_wait got=%b want=0", bus.hreadyout); end
    bus.hwdata = 32'h0BADF00D; bus.hready_in = 1'b0; bus.hwrite = 1'b0;
    @(negedge clk);
    vec++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin
      errs++; $display("FAIL b2b_write_final hreadyout=%b hresp=%b want 1 0", bus.hreadyout, bus.hresp); end
    bus.hready_in = 1'b1;
    @(negedge clk);
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = 32'h0;
    vec++; if (bus.hreadyout !== 1'b0) begin errs++; $display("FAIL b2b_read_wait got=%b want=0", bus.hreadyout); end
    @(negedge clk);
    vec++; if (bus.hreadyout !== 1'b1 || bus.hrdata !== 32'h0BADF00D) begin
      errs++; $display("FAIL b2b_read_data hreadyout=%b got=%h want 1 0BADF00D", bus.hreadyout, bus.hrdata); end
    bus_idle();
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; int lows; logic rl, rf;
    xfer(1'b1, 32'h204, 3'd2, 1'b0, 32'h11223344, rd, lows, rl, rf);
    @(negedge clk);
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h204; bus.hwrite = 1'b1; bus.hsize = 3'd2;
    @(negedge clk);
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = 32'h00000055;
    vec++; if (bus.hreadyout !== 1'b0) begin errs++; $display("FAIL rst_wait_entered got=%b want=0", bus.hreadyout); end
    reset = 1'b1;
    @(negedge clk);
    vec++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0 || bus.hrdata !== 32'd0) begin
      errs++; $display("FAIL rst_wait_outputs hreadyout=%b hresp=%b hrdata=%h want 1 0 00000000",
                       bus.hreadyout, bus.hresp, bus.hrdata); end
    reset = 1'b0;
    bus_idle();
    xfer(1'b0, 32'h204, 3'd2, 1'b0, 32'h0, rd, lows, rl, rf);
    vec++; if (rd !== 32'h11223344) begin errs++; $display("FAIL rst_wait_no_commit got=%h want=11223344", rd); end
  endtask

  task automatic test_write_protect();
    logic [31:0] rd; int lows; logic rl, rf;
    xfer(1'b1, 32'h100, 3'd2, 1'b0, 32'h600DCAFE, rd, lows, rl, rf);
    vec++; if (rl !== 1'b0 || rf !== 1'b0) begin errs++; $display("FAIL wp_limit_write resp=%b%b want=00", rl, rf); end
    xfer(1'b0, 32'h100, 3'd2, 1'b0, 32'h0, rd, lows, rl, rf);
    vec++; if (rd !== 32'h600DCAFE) begin errs++; $display("FAIL wp_limit_read got=%h want=600DCAFE", rd); end
    xfer(1'b1, 32'h0, 3'd2, 1'b0, 32'hCAFEF00D, rd, lows, rl, rf);
`ifdef AHB_SRAM_WRITE_PROTECT_EN
    vec++; if (rl !== 1'b1 || rf !== 1'b1) begin errs++; $display("FAIL wp_low_write resp=%b%b want=11", rl, rf); end
`else
    vec++; if (rl !== 1'b0 || rf !== 1'b0) begin errs++; $display("FAIL wp_low_write resp=%b%b want=00", rl, rf); end
`endif
    xfer(1'b0, 32'h0, 3'd2, 1'b0, 32'h0, rd, lows, rl, rf);
    vec++; if (rl !== 1'b0 || rf !== 1'b0) begin errs++; $display("FAIL wp_low_read_resp resp=%b%b want=00", rl, rf); end
`ifdef AHB_SRAM_WRITE_PROTECT_EN
    vec++; if (rd === 32'hCAFEF00D) begin errs++; $display("FAIL wp_low_no_commit got=%h want anything but CAFEF00D", rd); end
`else
    vec++; if (rd !== 32'hCAFEF00D) begin errs++; $display("FAIL wp_low_commit got=%h want=CAFEF00D", rd); end
`endif
  endtask

  initial begin
    bus_idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_word_rw();
    test_subword_read();
    test_partial_write();
    test_error();
    test_back_to_back();
    test_reset_in_wait();
    test_write_protect();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
